// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the dual-core CPU: word, ALU opcode and
// the ALU arbiter state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_SRA  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_NOR  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_arb_state_t;

endpackage

// File: rtl/alu_if.sv
// Connection between the single shared ALU and whoever drives its inputs.
interface alu_if;
  import cpu_types_pkg::*;

  aluop_t aluop;
  word_t  portA;
  word_t  portB;
  word_t  portOut;
  logic   negative;
  logic   overflow;
  logic   zero;

  modport alu (input aluop, portA, portB, output portOut, negative, overflow, zero);
  modport arb (output aluop, portA, portB, input portOut, negative, overflow, zero);
endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU; overflow is only meaningful for ADD/SUB.
module alu
  import cpu_types_pkg::*;
(
  alu_if.alu aluif
);

  word_t out;
  logic  ovf;

  always_comb begin
    out = '0;
    ovf = 1'b0;
    case (aluif.aluop)
      ALU_SLL:  out = aluif.portA << aluif.portB[4:0];
      ALU_SRL:  out = aluif.portA >> aluif.portB[4:0];
      ALU_SRA:  out = word_t'($signed(aluif.portA) >>> aluif.portB[4:0]);
      ALU_ADD: begin
        out = aluif.portA + aluif.portB;
        ovf = (aluif.portA[31] == aluif.portB[31]) && (out[31] != aluif.portA[31]);
      end
      ALU_SUB: begin
        out = aluif.portA - aluif.portB;
        ovf = (aluif.portA[31] != aluif.portB[31]) && (out[31] != aluif.portA[31]);
      end
      ALU_AND:  out = aluif.portA & aluif.portB;
      ALU_OR:   out = aluif.portA | aluif.portB;
      ALU_XOR:  out = aluif.portA ^ aluif.portB;
      ALU_NOR:  out = ~(aluif.portA | aluif.portB);
      ALU_SLT:  out = {31'b0, $signed(aluif.portA) < $signed(aluif.portB)};
      ALU_SLTU: out = {31'b0, aluif.portA < aluif.portB};
      default:  out = '0;
    endcase
  end

  assign aluif.portOut  = out;
  assign aluif.overflow = ovf;
  assign aluif.negative = out[31];
  assign aluif.zero     = (out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between core 0 and core 1; each grant
// runs IDLE -> EXEC -> RESP and ends with a done pulse to the owner.
module alu_arbiter
  import cpu_types_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  aluop_t     aluop0,
  input  aluop_t     aluop1,
  input  word_t      portA0,
  input  word_t      portB0,
  input  word_t      portA1,
  input  word_t      portB1,
  output logic [1:0] done,
  output word_t      result0,
  output word_t      result1,
  output logic [2:0] flags0,
  output logic [2:0] flags1,
  output logic       busy
);

  alu_arb_state_t state, next_state;
  aluop_t         op_r;
  word_t          a_r, b_r;
  logic           owner, prio, winner;
  logic [2:0]     alu_flags;

  alu_if aluif ();
  alu u_alu (.aluif(aluif));

  assign aluif.aluop = op_r;
  assign aluif.portA = a_r;
  assign aluif.portB = b_r;
  assign alu_flags   = {aluif.negative, aluif.overflow, aluif.zero};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Single requester wins outright; prio only breaks a tie.
  always_comb begin
    next_state = state;
    winner     = prio;
    if (req == 2'b01)      winner = 1'b0;
    else if (req == 2'b10) winner = 1'b1;
    case (state)
      IDLE:    if (req != 2'b00) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_r    <= ALU_SLL;
      a_r     <= '0;
      b_r     <= '0;
      owner   <= 1'b0;
      prio    <= RR_INIT;
      result0 <= '0;
      result1 <= '0;
      flags0  <= '0;
      flags1  <= '0;
    end else begin
      case (state)
        IDLE: if (req != 2'b00) begin
          owner <= winner;
          op_r  <= winner ? aluop1 : aluop0;
          a_r   <= winner ? portA1 : portA0;
          b_r   <= winner ? portB1 : portB0;
        end
        EXEC: if (owner) begin
          result1 <= aluif.portOut;
          flags1  <= alu_flags;
        end else begin
          result0 <= aluif.portOut;
          flags0  <= alu_flags;
        end
        RESP:    prio <= ~owner;
        default: ;
      endcase
    end
  end

  assign done = (state == RESP) ? {owner, ~owner} : 2'b00;
  assign busy = (state != IDLE);

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares one `alu` instance between two requesters, core 0 and core 1 of the dual-core datapath. Each request presents an opcode and two operands. The winner's operands are registered into the ALU, and the result and flags are captured into a per-requester output register. A one-cycle `done` pulse then tells the owner its result is ready. The block sits between the cores' execute-stage request ports and a single `alu` instance driven through `alu_if`.

## Interface
- `RR_INIT`, default 0: requester that holds priority after reset (0 or 1).
- `CLK`  in  1: clock, rising edge.
- `RST`  in  1: asynchronous reset, active-high.
- `req`  in  2: per-requester level request; bit i belongs to core i.
- `aluop0`, `aluop1`  in  `aluop_t`: opcode from each requester.
- `portA0`, `portB0`, `portA1`, `portB1`  in  `word_t` (32): operands from each requester.
- `done`  out  2: one-cycle pulse; bit i means requester i's result registers were updated.
- `result0`, `result1`  out  `word_t`: last result delivered to each requester.
- `flags0`, `flags1`  out  3: `{negative, overflow, zero}` of that result.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- FSM states are IDLE, EXEC and RESP, encoded as `alu_arb_state_t`.
- IDLE, no request pending: stay in IDLE.
- IDLE, `req != 0`: pick the winner and go to EXEC.
  - Only one `req` bit set: that requester wins.
  - Both bits set: the requester named by the priority register `prio` wins.
- Entering EXEC: latch the winner's opcode, `portA` and `portB` into the ALU input registers, and latch the winner's index into `owner`.
- EXEC: the ALU evaluates the latched inputs combinationally. At the end of the cycle, `portOut` and the flags are written into `result[owner]` and `flags[owner]`; go to RESP.
- RESP: drive `done[owner]`=1, set `prio` = ~`owner`, go to IDLE.
- `req` is not sampled in EXEC or RESP.
- Operands must stay stable only until the IDLE sampling edge; later changes have no effect.
- A requester still holding `req` high when the FSM returns to IDLE starts a new transaction.
- Results are never lost: `result1`/`flags1` hold their value while requester 0 is served, and the same holds for requester 0.
- Arithmetic, width and flag semantics are exactly those of `alu`; the block applies no sign-extension or truncation of its own.
- Reset values:
  - state IDLE, `prio` = `RR_INIT`, `owner` = 0;
  - `done` = 0, `busy` = 0;
  - `result0`/`result1` = 0, `flags0`/`flags1` = 0;
  - ALU input registers = 0.
- Reset asserted mid-transaction: the transaction is abandoned. No `done` is issued, and result registers return to 0.

## Timing
- `req` sampled at edge N in IDLE: EXEC runs in cycle N+1, the result registers load at edge N+1, and `done` is high for the cycle N+1 to N+2.
- Request-to-result latency is 2 edges. Issue interval is at most one transaction per 3 cycles.
- `done` is high in exactly the cycle after the result registers change. A requester may consume `result*` during the `done` cycle.
- `busy` rises at the edge that leaves IDLE and falls at the edge that enters IDLE.
- Fairness: with both `req` bits held high continuously, grants strictly alternate 0,1,0,1… when `RR_INIT`=0. No requester waits more than one transaction.
- Simultaneous events: a new `req` edge arriving in RESP is sampled at the next IDLE edge, not dropped.

## Structure
- Add `alu_arb_state_t` (IDLE, EXEC, RESP) to `cpu_types_pkg`. `aluop_t` and `word_t` already come from there.
- Instantiate one `alu` sub-module, connected through an `alu_if` instance. The arbiter drives `aluop`, `portA` and `portB` from its input registers and reads `portOut`, `negative`, `overflow` and `zero`.
- One FSM block, one datapath register block (input registers, `owner`, `prio`, result/flag registers), and a combinational next-state and winner-select block.

## Test plan
- Reset, then `req`=01 with ALU_ADD, 5, 7 → `done`=01 exactly 2 edges after sampling; `result0`=12, `flags0`=000; `result1` stays 0.
- `req`=10 with ALU_SUB, 3, 5 → `result1`=0xFFFFFFFE, `flags1`=100, `done`=10; `result0` unchanged at 12.
- Both `req` held high with `RR_INIT`=0 → `done` order 01, 10, 01, 10 at 3-cycle spacing, and `busy` drops for exactly 1 cycle between transactions.
- Requester 0 sends ALU_ADD, 0x7FFFFFFF, 1 → `result0`=0x80000000 and overflow flag set. Then ALU_SUB, 9, 9 → `result0`=0 and zero flag set.
- Change `portA0` and `aluop0` during EXEC → the captured result reflects only the values sampled at the IDLE edge.
- Assert `RST` during EXEC → no `done`, all outputs 0 asynchronously, and `prio` returns to `RR_INIT`; a following request completes normally.
